// File: rtl/lifo_rr_arbiter_if.sv
// Requester-side bus of the LIFO round-robin arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface lifo_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       op;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       rvalid;
  logic [WIDTH-1:0]         rdata;

  modport master (
    output req, op, wdata,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  req, op, wdata,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/lifo_rr_arbiter.sv
// Round-robin arbiter that shares one single-port LIFO stack among NUM_REQ requesters.
// Popped data returns one cycle after the grant, and the block tracks the stack's occupancy.
module lifo_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 16,
  parameter int DEPTH_P2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  lifo_rr_arbiter_if.slave      bus,
  output logic [DEPTH_P2:0]     count,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH-1:0]      stk_din,
  input  logic                  stk_empty,
  input  logic                  stk_full,
  input  logic [WIDTH-1:0]      stk_dout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = DEPTH_P2 + 1;
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(2 ** DEPTH_P2);
  localparam logic [PTR_W-1:0] LAST_ID  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   rr_ptr;
  logic               rsp_valid;
  logic [PTR_W-1:0]   rsp_id;
  logic [CNT_W-1:0]   count_q;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [PTR_W-1:0]   win;
  logic               grant;
  logic               win_pop;

  // A request is serviceable only when the stack can take it; others are skipped, not blocking.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req[i] & (bus.op[i] ? ~stk_empty : ~stk_full);
    end
  end

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  assign grant   = found & ~reset;
  assign win_pop = bus.op[win];

  assign bus.ack  = grant ? (NUM_REQ'(1) << win) : '0;
  assign stk_push = grant & ~win_pop;
  assign stk_pop  = grant &  win_pop;
  assign stk_din  = stk_push ? bus.wdata[win*WIDTH +: WIDTH] : '0;

  // Gating by reset suppresses a return for a pop that was granted just before reset.
  assign bus.rvalid = (rsp_valid && !reset) ? (NUM_REQ'(1) << rsp_id) : '0;
  assign bus.rdata  = (rsp_valid && !reset) ? stk_dout : '0;
  assign count      = reset ? '0 : count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      count_q   <= '0;
    end else begin
      rsp_valid <= stk_pop;
      if (grant) begin
        rr_ptr <= (win == LAST_ID) ? '0 : win + 1'b1;
        rsp_id <= win;
      end
      if (stk_push)     count_q <= count_q + 1'b1;
      else if (stk_pop) count_q <= count_q - 1'b1;
    end
  end

  a_empty_tracks : assert property (@(posedge clk) disable iff (reset)
    (count_q == '0) == stk_empty);
  a_full_tracks : assert property (@(posedge clk) disable iff (reset)
    (count_q == CAPACITY) == stk_full);

endmodule

// File: doc/lifo_rr_arbiter.md
Name: lifo_rr_arbiter

Overview:
Round-robin arbiter that shares one single-port LIFO stack among NUM_REQ requesters. Each requester posts a push or a pop. The block grants at most one serviceable request per cycle and drives the stack's push/pop/din. It routes popped data back to the winning requester with a one-cycle return pipeline, and keeps an occupancy count that the stack itself does not expose.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 16, data width; must match the stack
DEPTH_P2, 8, log2 of stack depth; must match the stack (capacity 2**DEPTH_P2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request; level, held until ack
op  input  NUM_REQ  per-requester operation: 0 = push, 1 = pop
wdata  input  NUM_REQ*WIDTH  push data; requester i uses bits [i*WIDTH +: WIDTH]
ack  output  NUM_REQ  one-hot; request accepted this cycle
rvalid  output  NUM_REQ  one-hot; pop data valid on rdata this cycle
rdata  output  WIDTH  popped data, shared bus
count  output  DEPTH_P2+1  current stack occupancy
stk_push  output  1  to stack push
stk_pop  output  1  to stack pop
stk_din  output  WIDTH  to stack din
stk_empty  input  1  from stack
stk_full  input  1  from stack
stk_dout  input  WIDTH  from stack; updated at the edge where pop is sampled

Behaviour:
- Eligibility, combinational, current cycle: elig[i] = req[i] & (op[i] ? ~stk_empty : ~stk_full).
- Ineligible requesters are skipped. They never block others and keep waiting with req held.
- Arbitration, combinational: search starts at index rr_ptr and proceeds rr_ptr+1, ..., wrapping modulo NUM_REQ. The first eligible index wins.
- On a grant to winner w, in the same cycle:
  - ack[w]=1.
  - Push: stk_push=1, stk_pop=0, stk_din = wdata slice w.
  - Pop: stk_pop=1, stk_push=0.
- Never assert stk_push and stk_pop together; the stack treats that pair as a no-op.
- No grant: ack=0, stk_push=stk_pop=0, stk_din=0.
- rr_ptr register:
  - Reset value 0.
  - On a grant, rr_ptr <= (w+1) mod NUM_REQ.
  - No grant: rr_ptr holds.
- Requester contract: deassert req, or present a new op, in the cycle after ack. Holding req keeps it in arbitration as a fresh request.
- Pop return, one-cycle latency:
  - On a pop grant at edge N, register rsp_valid=1 and rsp_id=w.
  - In cycle N+1: rvalid[rsp_id]=1 and rdata=stk_dout. rdata is combinational from the stack's registered dout.
  - rvalid is 0 whenever rsp_valid=0.
  - Back-to-back pops to different requesters are allowed; one rvalid per cycle.
- Occupancy:
  - count +1 on a push grant, -1 on a pop grant.
  - Range 0..2**DEPTH_P2.
  - Invariants: count==0 iff stk_empty; count==2**DEPTH_P2 iff stk_full. Assert both in simulation.
- Reset, applied together with the stack's reset: rr_ptr=0, rsp_valid=0, rsp_id=0, count=0.
  - All outputs 0 during reset: ack, rvalid, stk_push, stk_pop, rdata, count.
  - ack=0 and no stack strobes while reset=1.
  - A pop granted in the cycle before reset asserts produces no rvalid.
- Boundaries:
  - Full with push+pop requests pending: only pops are eligible, so the pop wins regardless of rr_ptr.
  - Empty: only pushes are eligible.
  - Single eligible requester: granted every cycle it requests.
  - No requests: rr_ptr and count hold.

Test Plan:
- Reset, then req=0001, op=0, wdata0=0x1234 -> ack=0001, stk_push=1, stk_din=0x1234. Next cycle count=1, rr_ptr=1.
- Requesters 0 and 2 pop after pushes of 0xAAAA then 0xBBBB -> requester 0 granted first; rvalid=0001, rdata=0xBBBB the next cycle. Requester 2 granted the following cycle and receives 0xAAAA with rvalid=0100.
- All four request push continuously from rr_ptr=0 -> ack sequence 0001, 0010, 0100, 1000, 0001. count increments by 1 per cycle.
- Fill to count=256: requester 1 push and requester 3 pop pending -> ack=1000 only, requester 1 waits. count=255 next, then requester 1 acked.
- Empty stack, requester 0 pop and requester 1 push -> requester 1 acked first, requester 0 acked next cycle and returns requester 1's data.
- Pop granted, reset asserted the next edge -> no rvalid; all outputs 0; count=0; rr_ptr=0.
